// File: rtl/alu_muldiv.sv
// Multi-cycle EX-stage ALU with the RV32M multiply/divide group behind a valid/ready handshake.
// Base ops complete in one cycle; M-ops iterate one radix-2 step per cycle on operand magnitudes.
module alu_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SHA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_A    = 4'd10;
    localparam logic [3:0] ALU_B    = 4'd11;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [2:0]         fn_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   count;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   base_res;
    logic               a_signed, b_signed, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, trial, diff;
    logic [2*WIDTH-1:0] acc_next, prod;
    logic [WIDTH-1:0]   quot, rem, final_res;
    logic               accept;

    assign in_ready = rst_n && (state == IDLE);
    assign accept   = in_valid && in_ready && !kill;
    assign zero     = (result == '0);
    assign shamt    = b[SHAMT_W-1:0];

    always_comb begin
        base_res = '0;
        case (op[3:0])
            ALU_ADD:  base_res = a + b;
            ALU_SUB:  base_res = a - b;
            ALU_SLL:  base_res = a << shamt;
            ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, a < b};
            ALU_XOR:  base_res = a ^ b;
            ALU_SRL:  base_res = a >> shamt;
            ALU_SHA:  base_res = $unsigned($signed(a) >>> shamt);
            ALU_OR:   base_res = a | b;
            ALU_AND:  base_res = a & b;
            ALU_A:    base_res = a;
            ALU_B:    base_res = b;
            default:  base_res = '0;
        endcase
    end

    // Signedness per funct3: MULH both, MULHSU a only, DIV/REM both, the rest unsigned.
    always_comb begin
        if (op[2]) begin
            a_signed = !op[0];
            b_signed = !op[0];
        end else begin
            a_signed = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
            b_signed = (op[1:0] == 2'b01);
        end
        sign_a = a_signed && a[WIDTH-1];
        sign_b = b_signed && b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        trial   = acc[2*WIDTH-1:WIDTH-1];
        diff    = trial - {1'b0, opnd};
        if (fn_q[2])
            acc_next = diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        prod = neg_q ? -acc_next : acc_next;
        quot = acc_next[WIDTH-1:0];
        rem  = acc_next[2*WIDTH-1:WIDTH];
        case (fn_q)
            3'd0:       final_res = prod[WIDTH-1:0];
            3'd4, 3'd5: final_res = (b_q == '0) ? '1  : (neg_q ? -quot : quot);
            3'd6, 3'd7: final_res = (b_q == '0) ? a_q : (neg_r ? -rem : rem);
            default:    final_res = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    // Control FSM; kill overrides everything except the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fn_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd      <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            count     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fn_q <= op[2:0];
                        a_q  <= a;
                        b_q  <= b;
                        if (op[4]) begin
                            state <= BUSY;
                            count <= CNT_W'(WIDTH);
                            acc   <= {{WIDTH{1'b0}}, op[2] ? mag_a : mag_b};
                            opnd  <= op[2] ? mag_b : mag_a;
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= sign_a;
                        end else begin
                            state     <= DONE;
                            result    <= base_res;
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state     <= DONE;
                        result    <= final_res;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors push expected results, a monitor pops them on handshake.
module tb_alu_muldiv;

    localparam int WIDTH = 32;

    localparam logic [4:0] ADD  = 5'd0,  SUB  = 5'd1,  SLL = 5'd2,  SLT = 5'd3;
    localparam logic [4:0] SLTU = 5'd4,  XOR_ = 5'd5,  SRL = 5'd6,  SHA = 5'd7;
    localparam logic [4:0] OR_  = 5'd8,  AND_ = 5'd9,  PA  = 5'd10, PB  = 5'd11, UNDEF = 5'd15;
    localparam logic [4:0] MUL  = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
    localparam logic [4:0] DIV  = 5'h14, DIVU = 5'h15, REM    = 5'h16, REMU  = 5'h17;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             kill = 1'b0;
    logic             out_ready = 1'b1;
    logic [4:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic             zero;
    logic [WIDTH-1:0] result;

    typedef struct packed {
        logic [7:0]       id;
        logic [WIDTH-1:0] res;
        logic             z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   next_id = 0;

    alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_output: got 0x%08h, want no output", result);
            end else begin
                mon_e = sb.pop_front();
                checkOutput($sformatf("result#%0d", mon_e.id), result, mon_e.res);
                checkOutput($sformatf("zero#%0d", mon_e.id), {31'b0, zero}, {31'b0, mon_e.z});
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] exp, input bit expect_out, input int exp_lat);
        int guard = 0;
        int lat;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        if (expect_out) begin
            sb.push_back('{id: 8'(next_id), res: exp, z: (exp == '0)});
            next_id++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (exp_lat > 0) begin
            lat = 1;
            while (!out_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput($sformatf("latency op%02h", o), lat, exp_lat);
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (out_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (out_valid) checkOutput("drain_timeout", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic runOp(input logic [4:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] exp);
        applyStimulus(o, x, y, exp, 1'b1, o[4] ? WIDTH + 1 : 1);
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int seen;
        logic [WIDTH-1:0] hold;

        #2;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zero", {31'b0, zero}, 32'd1);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);

        runOp(ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000);
        runOp(SHA,   32'h80000000, 32'h4,        32'hF8000000);
        runOp(SLT,   32'hFFFFFFFF, 32'h1,        32'h1);
        runOp(SLTU,  32'hFFFFFFFF, 32'h1,        32'h0);
        runOp(SUB,   32'h5,        32'h5,        32'h0);
        runOp(SLL,   32'h1,        32'h21,       32'h2);
        runOp(SRL,   32'h80000000, 32'h4,        32'h08000000);
        runOp(XOR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        runOp(OR_,   32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0);
        runOp(AND_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        runOp(PA,    32'h12345678, 32'h9ABCDEF0, 32'h12345678);
        runOp(PB,    32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0);
        runOp(UNDEF, 32'h12345678, 32'h9ABCDEF0, 32'h0);

        runOp(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
        runOp(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runOp(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        runOp(MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF);
        runOp(MULH,   32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF);
        runOp(MUL,    32'd12345,    32'd6789,     32'h04FED79D);

        runOp(DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD);
        runOp(REM,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
        runOp(DIVU, 32'h5,        32'h0,        32'hFFFFFFFF);
        runOp(REMU, 32'h5,        32'h0,        32'h5);
        runOp(DIV,  32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF);
        runOp(REM,  32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB);
        runOp(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        runOp(REM,  32'h80000000, 32'hFFFFFFFF, 32'h0);
        runOp(DIVU, 32'd100,      32'd7,        32'd14);
        runOp(REMU, 32'd100,      32'd7,        32'd2);

        // Back-pressure on a finished MULHU.
        out_ready = 1'b0;
        applyStimulus(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, WIDTH + 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_result", result, 32'hFFFFFFFE);
            checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        runOp(ADD, 32'd10, 32'd20, 32'd30);

        // Kill at cycle 10 of a DIV.
        applyStimulus(DIV, 32'd100, 32'd3, 32'd0, 1'b0, 0);
        repeat (8) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checkOutput("kill_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("kill_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("kill_no_valid", seen, 32'd0);
        runOp(ADD, 32'd2, 32'd3, 32'd5);

        // A request coinciding with kill is dropped.
        op = ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        checkOutput("kill_req_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("kill_req_in_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of a DIVU.
        applyStimulus(DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 0);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_zero", {31'b0, zero}, 32'd1);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_release_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_stale", seen, 32'd0);
        hold = result;
        checkOutput("midrst_result_after", hold, 32'd0);
        runOp(SUB, 32'd9, 32'd4, 32'd5);

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multi-cycle successor to the single-cycle integer ALU. Executes all base ALU operations with one registered cycle of latency, plus the RV32M multiply/divide group through an iterative radix-2 datapath. Sits in the EX stage behind a valid/ready handshake so the pipeline stalls on long operations. A synchronous kill aborts an in-flight operation on a branch flush.

Parameters:
WIDTH, 32, operand and result width in bits (power of 2, >= 8)
SHAMT_W, $clog2(WIDTH), number of low bits of b used as the shift amount

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
op  input  5  op[4]=0: base op, op[3:0] uses the ALU_* codes from CONSTANT.v; op[4]=1: M-op, op[2:0]=funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
a  input  WIDTH  operand A (rs1)
b  input  WIDTH  operand B (rs2 or immediate)
kill  input  1  abort the current operation
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, result=0, zero=1, in_ready=0 while rst_n is low, then 1 in IDLE. Internal accumulators cleared.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Request accepted when in_valid && in_ready. Operands and op are latched on acceptance.
- Base op accepted: goes directly to DONE; result is valid on the next cycle (latency 1).
- M-op accepted: goes to BUSY with counter=WIDTH.
- BUSY: one radix-2 step per cycle. At counter==1 the result is finalised and the next state is DONE, so latency is WIDTH+1 cycles from acceptance to out_valid.
- DONE: out_valid=1; result and zero are held stable until out_valid && out_ready, then return to IDLE. in_ready=0 in DONE, so there is no back-to-back accept in the handover cycle.
- kill (synchronous, highest priority after reset): from any state go to IDLE next cycle with out_valid=0. A request presented in the same cycle as kill is not accepted.
- Base-op semantics are identical to the existing ALU at width WIDTH:
  - shifts use b[SHAMT_W-1:0]; SHA is arithmetic.
  - SLT is signed, SLTU is unsigned.
  - ALU_A passes a; ALU_B passes b.
  - An undefined base code gives result=0.
- Multiply:
  - full 2*WIDTH product from the iterative step.
  - MUL returns the low half.
  - MULH treats a and b as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned. All three return the high half.
  - Signed handling: operate on magnitudes and negate the product when the signs differ.
- Divide (restoring, on magnitudes; sign fixed up at the end):
  - quotient rounds toward zero; remainder takes the sign of the dividend.
  - divide by zero: DIV/DIVU give all ones; REM/REMU give a. The full WIDTH+1 latency still applies.
  - signed overflow (a=MIN_INT, b=-1): DIV gives MIN_INT, REM gives 0.
- zero is computed from the registered result and is valid only while out_valid=1.
- out_valid=1 with out_ready=0 indefinitely: result is held with no change and the block is not corrupted.

Test Plan:
- Reset mid-BUSY: start DIVU 100/7, assert rst_n=0 at cycle 5 -> out_valid=0, result=0, in_ready=1 after release; no stale result appears.
- Base ops, WIDTH=32: ADD 0x7FFFFFFF+1 -> 0x80000000 on the cycle after accept; SHA 0x80000000>>>4 -> 0xF8000000; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; SUB 5-5 -> 0 with zero=1.
- Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> 1; MULHU same operands -> 0xFFFFFFFE; MULH -> 0; MULHSU a=-1, b=2 -> 0xFFFFFFFF. out_valid asserts exactly 33 cycles after accept.
- Divide corners: DIV -7/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF and REMU -> 5; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- Back-pressure: hold out_ready=0 for 10 cycles after a MULHU completes -> result stable, in_ready=0; release -> IDLE the next cycle and a new request is accepted.
- Kill: assert kill at cycle 10 of a DIV -> IDLE next cycle, out_valid never rises; a following ADD 2+3 returns 5.
